score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/digits_pkg.sv | 37 +++
 rtl/bcd_digit.sv | 32 +++
 rtl/segments_to_bitmap.sv | 26 ++
 rtl/seven_segment_decoder.sv | 26 ++
 rtl/score_display.sv | 189 ++++++++++++++++++
 tb/tb_score_display.sv | 181 ++++++++++++++++++
 6 files changed

// File: rtl/digits_pkg.sv
// digits_pkg: constants, types and the segment bitmap table shared by the
// score_display slice (counter digits, glyph rendering, pixel pipeline).
package digits_pkg;

  localparam int unsigned GLYPH_W    = 5;  // glyph columns, left-aligned in cell
  localparam int unsigned GLYPH_H    = 8;  // glyph rows
  localparam int unsigned CELL_W     = 8;  // unscaled cell width/height
  localparam int unsigned PIPE_DEPTH = 2;  // raster-to-RGB latency in cycles

  typedef logic [3:0] bcd_t;

  // Each segment lights the outer product of a row mask (bit = font row)
  // and a column mask (bit = font column, column 0 leftmost).
  // Segment order is {g,f,e,d,c,b,a}; index 0 = a.
  localparam logic [7:0] SEG_ROWS [7] = '{
    8'b0000_0001,  // a: top bar
    8'b0000_1111,  // b: upper right
    8'b0111_1000,  // c: lower right
    8'b0100_0000,  // d: bottom bar
    8'b0111_1000,  // e: lower left
    8'b0000_1111,  // f: upper left
    8'b0000_1000   // g: middle bar
  };
  localparam logic [4:0] SEG_COLS [7] = '{
    5'b11111, 5'b10000, 5'b10000, 5'b11111, 5'b00001, 5'b00001, 5'b11111
  };

  // Stage-1 pixel pipeline contents.
  typedef struct packed {
    logic       in_field;
    logic       de;
    logic [2:0] sel;  // digit index, 0 = least significant
    logic [2:0] row;  // font row
    logic [2:0] col;  // font column within cell (5..7 blank)
  } pix_s1_t;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decimal counter digit with ripple carry.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_clear : synchronous clear to zero
//   i_carry : increment this digit (carry in)
//   o_carry : carry to next digit (combinational, same cycle)
//   o_nib   : current BCD value, never above 9
module bcd_digit
  import digits_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_carry,
  output logic o_carry,
  output bcd_t o_nib
);

  bcd_t r_nib;

  assign o_carry = i_carry & (r_nib == 4'd9);
  assign o_nib   = r_nib;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_nib <= '0;
    end else if (i_carry) begin
      r_nib <= (r_nib == 4'd9) ? 4'd0 : r_nib + 4'd1;
    end
  end

endmodule

// File: rtl/segments_to_bitmap.sv
// segments_to_bitmap: renders one font pixel of a 5x8 glyph from segments.
//   i_seg : {g,f,e,d,c,b,a}
//   i_row : font row 0..7
//   i_col : font column 0..7 (columns 5..7 always dark)
//   o_pix : 1 = lit
module segments_to_bitmap
  import digits_pkg::*;
(
  input  logic [6:0] i_seg,
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  output logic       o_pix
);

  always_comb begin
    o_pix = 1'b0;
    if (i_col < 3'(GLYPH_W)) begin
      for (int unsigned s = 0; s < 7; s++) begin
        if (i_seg[s] && SEG_ROWS[s][i_row] && SEG_COLS[s][i_col]) begin
          o_pix = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: BCD digit to segment enables.
//   i_bcd : digit 0..9 (others give all segments off)
//   o_seg : {g,f,e,d,c,b,a}, 1 = lit
module seven_segment_decoder (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = '0;
    case (i_bcd)
      4'd0: o_seg = 7'b0111111;
      4'd1: o_seg = 7'b0000110;
      4'd2: o_seg = 7'b1011011;
      4'd3: o_seg = 7'b1001111;
      4'd4: o_seg = 7'b1100110;
      4'd5: o_seg = 7'b1101101;
      4'd6: o_seg = 7'b1111101;
      4'd7: o_seg = 7'b0000111;
      4'd8: o_seg = 7'b1111111;
      4'd9: o_seg = 7'b1101111;
      default: o_seg = '0;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// score_display: BCD score counter rendered as a row of 7-segment style
// glyphs over a raster from video_sync_generator.
//   Clock, reset            : clock, synchronous active-high reset
//   inc, clear              : increment request, clear request (clear wins)
//   hpos, vpos              : raster position
//   display_on, hsync_in,
//   vsync_in                : raster timing in
//   hsync, vsync            : timing delayed to match pixel data
//   VGA_R, VGA_G, VGA_B     : pixel colour
//   value                   : live BCD count, digit 0 in [3:0]
//   overflow                : sticky wrap/saturation flag
module score_display
  import digits_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter logic [9:0]  X0         = 10'd0,
  parameter logic [9:0]  Y0         = 10'd0,
  parameter logic [11:0] COLOR      = 12'h0F0,
  parameter bit          SATURATE   = 1'b0,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input  logic                    Clock,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clear,
  input  logic [9:0]              hpos,
  input  logic [9:0]              vpos,
  input  logic                    display_on,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  output logic                    hsync,
  output logic                    vsync,
  output logic [3:0]              VGA_R,
  output logic [3:0]              VGA_G,
  output logic [3:0]              VGA_B,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    overflow
);

  localparam int unsigned CELL_SHIFT = $clog2(CELL_W) + SCALE_LOG2;
  localparam int unsigned FIELD_W    = NUM_DIGITS << CELL_SHIFT;
  localparam int unsigned FIELD_H    = GLYPH_H << SCALE_LOG2;

  // ---------------- counter ----------------
  logic [4*NUM_DIGITS-1:0] w_value;
  logic w_all_nines, w_sat_block, w_inc_eff, w_wrap;
  logic r_overflow;

  always_comb begin
    w_all_nines = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_value[4*i +: 4] != 4'd9) w_all_nines = 1'b0;
    end
  end

  // Saturation is done by withholding the carry into digit 0.
  assign w_sat_block = inc & SATURATE & w_all_nines;
  assign w_inc_eff   = inc & ~w_sat_block;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    logic w_cin, w_cout;
    if (i == 0) begin : g_lsb
      assign w_cin = w_inc_eff;
    end else begin : g_rip
      assign w_cin = g_dig[i-1].w_cout;
    end
    bcd_digit u_digit (
      .i_clk   (Clock),
      .i_rst   (reset),
      .i_clear (clear),
      .i_carry (w_cin),
      .o_carry (w_cout),
      .o_nib   (w_value[4*i +: 4])
    );
  end

  assign w_wrap = g_dig[NUM_DIGITS-1].w_cout;

  always_ff @(posedge Clock) begin
    if (reset || clear) begin
      r_overflow <= 1'b0;
    end else if (w_wrap || w_sat_block) begin
      r_overflow <= 1'b1;
    end
  end

  assign value    = w_value;
  assign overflow = r_overflow;

  // ---------------- frame shadow ----------------
  logic [4*NUM_DIGITS-1:0] r_shadow;

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (hpos == '0 && vpos == '0) begin
      r_shadow <= w_value;
    end
  end

  // ---------------- stage 1: position decode ----------------
  logic [9:0] w_dx, w_dy;
  pix_s1_t    w_s1, r_s1;
  logic [PIPE_DEPTH-1:0] r_hs_dly, r_vs_dly;

  assign w_dx = hpos - X0;
  assign w_dy = vpos - Y0;

  always_comb begin
    w_s1          = '0;
    w_s1.in_field = (hpos >= X0) && (vpos >= Y0) &&
                    ({1'b0, w_dx} < 11'(FIELD_W)) &&
                    ({1'b0, w_dy} < 11'(FIELD_H));
    w_s1.de       = display_on;
    // Leftmost cell holds the most-significant digit.
    w_s1.sel      = 3'(NUM_DIGITS - 1) - 3'(w_dx >> CELL_SHIFT);
    w_s1.col      = 3'(w_dx >> SCALE_LOG2);
    w_s1.row      = 3'(w_dy >> SCALE_LOG2);
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_s1     <= '0;
      r_hs_dly <= '0;
      r_vs_dly <= '0;
    end else begin
      r_s1     <= w_s1;
      r_hs_dly <= {r_hs_dly[PIPE_DEPTH-2:0], hsync_in};
      r_vs_dly <= {r_vs_dly[PIPE_DEPTH-2:0], vsync_in};
    end
  end

  // ---------------- stage 2: glyph lookup ----------------
  logic [NUM_DIGITS-1:0] w_lz;        // bit i: digits i..MSD all zero
  logic                  w_zero_run;
  bcd_t                  w_nib;
  logic                  w_blank;
  logic [6:0]            w_seg;
  logic                  w_pix, w_lit;
  logic [11:0]           r_rgb;

  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_zero_run = w_zero_run & (r_shadow[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      w_lz[NUM_DIGITS-1-k] = w_zero_run;
    end
  end

  always_comb begin
    w_nib   = '0;
    w_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_s1.sel == 3'(i)) begin
        w_nib   = r_shadow[4*i +: 4];
        w_blank = BLANK_LZ && (i != 0) && w_lz[i];
      end
    end
  end

  seven_segment_decoder u_dec (
    .i_bcd (w_nib),
    .o_seg (w_seg)
  );

  segments_to_bitmap u_bmp (
    .i_seg (w_seg),
    .i_row (r_s1.row),
    .i_col (r_s1.col),
    .o_pix (w_pix)
  );

  assign w_lit = r_s1.in_field & r_s1.de & w_pix & ~w_blank;

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_lit ? COLOR : '0;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = r_rgb;
  assign hsync = r_hs_dly[PIPE_DEPTH-1];
  assign vsync = r_vs_dly[PIPE_DEPTH-1];

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: two instances sharing stimulus.
//   dut0: SATURATE=0, BLANK_LZ=1, field at (0,0)
//   dut1: SATURATE=1, BLANK_LZ=0, field at (80,40)
module tb_score_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, inc, clear, display_on, hsync_in, vsync_in;
  logic [9:0] hpos, vpos;

  logic        hs0, vs0, ovf0;
  logic [3:0]  r0, g0, b0;
  logic [15:0] value0;
  logic        hs1, vs1, ovf1;
  logic [3:0]  r1, g1, b1;
  logic [15:0] value1;

  int checks   = 0;
  int failures = 0;

  score_display #(
    .NUM_DIGITS(4), .SCALE_LOG2(1), .X0(10'd0), .Y0(10'd0),
    .COLOR(12'h0F0), .SATURATE(1'b0), .BLANK_LZ(1'b1)
  ) dut0 (
    .Clock(clk), .reset(reset), .inc(inc), .clear(clear),
    .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hsync(hs0), .vsync(vs0), .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
    .value(value0), .overflow(ovf0)
  );

  score_display #(
    .NUM_DIGITS(4), .SCALE_LOG2(1), .X0(10'd80), .Y0(10'd40),
    .COLOR(12'h0F0), .SATURATE(1'b1), .BLANK_LZ(1'b0)
  ) dut1 (
    .Clock(clk), .reset(reset), .inc(inc), .clear(clear),
    .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hsync(hs1), .vsync(vs1), .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .value(value1), .overflow(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; inc = 1'b0; clear = 1'b0;
    hpos = 10'd700; vpos = 10'd500;
    display_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) tick();
    check("rst_value0", value0, 16'h0000);
    check("rst_ovf0",   ovf0,   1'b0);
    check("rst_rgb0",   {r0, g0, b0}, 12'h000);
    check("rst_hs0",    hs0,    1'b0);
    check("rst_vs0",    vs0,    1'b0);
    check("rst_value1", value1, 16'h0000);
    reset = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;

    // 1234 increments
    inc = 1'b1; repeat (1234) tick(); inc = 1'b0;
    check("cnt1234_value0", value0, 16'h1234);
    check("cnt1234_ovf0",   ovf0,   1'b0);
    check("cnt1234_value1", value1, 16'h1234);

    // count up to all-nines then one more
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_value0", value0, 16'h0000);
    inc = 1'b1; repeat (9999) tick(); inc = 1'b0;
    check("nines_value0", value0, 16'h9999);
    check("nines_value1", value1, 16'h9999);
    check("nines_ovf0",   ovf0,   1'b0);
    inc = 1'b1; tick(); inc = 1'b0;
    check("wrap_value0", value0, 16'h0000);
    check("wrap_ovf0",   ovf0,   1'b1);
    check("sat_value1",  value1, 16'h9999);
    check("sat_ovf1",    ovf1,   1'b1);
    inc = 1'b1; tick(); inc = 1'b0;
    check("after_wrap_value0", value0, 16'h0001);
    check("sticky_ovf0",       ovf0,   1'b1);
    check("sat_hold_value1",   value1, 16'h9999);

    // clear drops overflow; then clear beats a simultaneous inc at 0042
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_ovf0",   ovf0,   1'b0);
    check("clr_ovf1",   ovf1,   1'b0);
    check("clr_value1", value1, 16'h0000);
    inc = 1'b1; repeat (42) tick(); inc = 1'b0;
    check("v42_value0", value0, 16'h0042);
    inc = 1'b1; clear = 1'b1; tick(); inc = 1'b0; clear = 1'b0;
    check("incclr_value0", value0, 16'h0000);
    check("incclr_ovf0",   ovf0,   1'b0);
    check("incclr_value1", value1, 16'h0000);

    // frame coherence at value 7 (dut0 digit 0 cell: hpos 48..63)
    inc = 1'b1; repeat (7) tick(); inc = 1'b0;
    hpos = 10'd0; vpos = 10'd0; tick();
    display_on = 1'b1;
    hpos = 10'd48; vpos = 10'd0; tick(); tick();
    check("seven_seg_a", {r0, g0, b0}, 12'h0F0);
    hpos = 10'd48; vpos = 10'd6; tick(); tick();
    check("seven_seg_g", {r0, g0, b0}, 12'h000);
    inc = 1'b1; tick(); inc = 1'b0;
    check("v8_value0", value0, 16'h0008);
    tick(); tick();
    check("midframe_still7", {r0, g0, b0}, 12'h000);
    hpos = 10'd0; vpos = 10'd0; tick();
    hpos = 10'd48; vpos = 10'd6; tick(); tick();
    check("nextframe_8_seg_g", {r0, g0, b0}, 12'h0F0);

    // value 0001 with leading zeros blanked; scan font row 1
    clear = 1'b1; tick(); clear = 1'b0;
    inc = 1'b1; tick(); inc = 1'b0;
    check("v1_value0", value0, 16'h0001);
    hpos = 10'd0; vpos = 10'd0; tick();
    vpos = 10'd2;
    for (int h = 40; h < 64; h++) begin
      hpos = 10'(h);
      tick();
      // after this edge the output belongs to the pixel presented one step earlier
      if (h >= 41) begin
        check($sformatf("scan_h%0d", h - 1), {r0, g0, b0},
              ((h - 1 == 56) || (h - 1 == 57)) ? 32'h0F0 : 32'h000);
      end
    end
    hpos = 10'd56; vpos = 10'd13; tick(); tick();
    check("one_row6", {r0, g0, b0}, 12'h0F0);
    hpos = 10'd57; vpos = 10'd14; tick(); tick();
    check("one_row7", {r0, g0, b0}, 12'h000);
    hpos = 10'd2; vpos = 10'd1; tick(); tick();
    check("lz_blank0", {r0, g0, b0}, 12'h000);
    hpos = 10'd80; vpos = 10'd40; tick(); tick();
    check("lz_drawn1",     {r1, g1, b1}, 12'h0F0);
    check("outside_field0", {r0, g0, b0}, 12'h000);
    display_on = 1'b0; hpos = 10'd56; vpos = 10'd2; tick(); tick();
    check("display_off0", {r0, g0, b0}, 12'h000);

    // reset mid-frame inside dut1's field
    display_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; vpos = 10'd50;
    hpos = 10'd96; tick();
    hpos = 10'd97; tick();
    check("pre_rst_rgb1", {r1, g1, b1}, 12'h0F0);
    hpos = 10'd98; tick();
    hpos = 10'd99; tick();
    check("pre_rst_hs1", hs1, 1'b1);
    hpos = 10'd100; reset = 1'b1; tick();
    check("rst1_rgb1", {r1, g1, b1}, 12'h000);
    check("rst1_hs1",  hs1, 1'b0);
    tick();
    check("rst2_rgb1", {r1, g1, b1}, 12'h000);
    check("rst2_hs1",  hs1, 1'b0);
    check("rst2_vs1",  vs1, 1'b0);
    check("rst2_hs0",  hs0, 1'b0);
    check("rst_mid_value1", value1, 16'h0000);
    check("rst_mid_value0", value0, 16'h0000);
    reset = 1'b0; hpos = 10'd96; tick(); tick();
    check("resume_rgb1", {r1, g1, b1}, 12'h0F0);
    check("resume_hs1",  hs1, 1'b1);
    check("resume_vs1",  vs1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
